// File: rtl/frame_buffer_port.sv
// Single-port SPRAM arbiter between the capture write queue and the VGA scanout.
// Scanout reads take absolute priority; the 4x scaled window leaves 3 of 4 active cycles free for writes.
module frame_buffer_port #(
  parameter int IMG_W       = 128,
  parameter int IMG_H       = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int WIN_X0      = 64,
  parameter int WIN_Y0      = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_valid,
  input  logic [7:0]  i_wr_data,
  output logic        o_wr_ready,
  input  logic        i_frame_start,
  output logic        o_dropped,
  input  logic        i_vga_valid,
  input  logic [9:0]  i_row,
  input  logic [9:0]  i_col,
  input  logic        i_hsync_in,
  input  logic        i_vsync_in,
  output logic [13:0] o_spram_addr,
  output logic [15:0] o_spram_di,
  output logic        o_spram_we,
  input  logic [15:0] i_spram_do,
  output logic [5:0]  o_rgb,
  output logic        o_hsync_out,
  output logic        o_vsync_out
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int WIN_W = IMG_W << SCALE_SHIFT;
  localparam int WIN_H = IMG_H << SCALE_SHIFT;

  logic [10:0]   w_dx, w_dy;
  logic          w_in_win, w_rd_slot;
  logic [13:0]   w_rd_addr;
  logic          w_full, w_push, w_pop, w_wr_ok;
  logic [PW-1:0] w_wr_idx;
  logic          w_unused;

  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0]   r_cnt;
  logic          r_ready_en;
  logic [14:0]   r_waddr;
  logic          r_dropped;
  logic [13:0]   r_addr;
  logic [15:0]   r_di;
  logic          r_we;
  logic          r_rd_d1, r_rd_d2;
  logic [2:0]    r_win_d, r_hs_d, r_vs_d;
  logic [7:0]    r_pix;

  // Offsets are one bit wider so a coordinate left of / above the window shows as negative.
  assign w_dx      = {1'b0, i_col} - 11'(WIN_X0);
  assign w_dy      = {1'b0, i_row} - 11'(WIN_Y0);
  assign w_in_win  = i_vga_valid
                   & ~w_dx[10] & (w_dx[9:0] < 10'(WIN_W))
                   & ~w_dy[10] & (w_dy[9:0] < 10'(WIN_H));
  assign w_rd_slot = w_in_win & (w_dx[SCALE_SHIFT-1:0] == '0);
  assign w_rd_addr = 14'(32'(w_dy[9:SCALE_SHIFT]) * IMG_W + 32'(w_dx[9:SCALE_SHIFT]));
  assign w_unused  = ^{i_spram_do[15:8], w_dy[SCALE_SHIFT-1:0]};

  assign w_full     = (r_cnt == (PW+1)'(FIFO_DEPTH));
  assign o_wr_ready = r_ready_en & ~w_full;
  assign w_push     = i_wr_valid & o_wr_ready;
  assign w_pop      = ~i_frame_start & ~w_rd_slot & (r_cnt != '0);
  assign w_wr_idx   = i_frame_start ? '0 : r_wp;
  assign w_wr_ok    = (r_waddr < 15'(NPIX));

  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[w_wr_idx] <= i_wr_data;
  end

  // frame_start restarts the queue, keeping only a pixel accepted on the same edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (i_frame_start) begin
        r_rp  <= '0;
        r_wp  <= PW'(w_push);
        r_cnt <= (PW+1)'(w_push);
      end else begin
        if (w_push) r_wp <= r_wp + 1'b1;
        if (w_pop)  r_rp <= r_rp + 1'b1;
        r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_addr    <= '0;
      r_di      <= '0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (i_frame_start) begin
        r_waddr   <= '0;
        r_dropped <= 1'b0;
      end
      if (w_rd_slot) begin
        r_addr <= w_rd_addr;
      end else if (w_pop) begin
        if (w_wr_ok) begin
          r_we    <= 1'b1;
          r_addr  <= r_waddr[13:0];
          r_di    <= {8'h00, r_fifo[r_rp]};
          r_waddr <= r_waddr + 1'b1;
        end else begin
          r_dropped <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_d1 <= 1'b0;
      r_rd_d2 <= 1'b0;
      r_win_d <= '0;
      r_hs_d  <= '1;
      r_vs_d  <= '1;
      r_pix   <= '0;
    end else begin
      r_rd_d1 <= w_rd_slot;
      r_rd_d2 <= r_rd_d1;
      r_win_d <= {r_win_d[1:0], w_in_win};
      r_hs_d  <= {r_hs_d[1:0], i_hsync_in};
      r_vs_d  <= {r_vs_d[1:0], i_vsync_in};
      if (r_rd_d2) r_pix <= i_spram_do[7:0];
    end
  end

  assign o_spram_addr = r_addr;
  assign o_spram_di   = r_di;
  assign o_spram_we   = r_we;
  assign o_dropped    = r_dropped;
  assign o_rgb        = r_win_d[2] ? {r_pix[7:6], r_pix[7:6], r_pix[7:6]} : 6'b000000;
  assign o_hsync_out  = r_hs_d[2];
  assign o_vsync_out  = r_vs_d[2];

endmodule
